// File: rtl/riscv_package.sv
// Shared encodings for the branch compare unit: branch conditions, ALU op
// classes and the flag bundle that travels down the result pipeline.
package riscv_package;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_cond_e;

    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_SLT    = 2'b10;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    // The SLT/SLTU result is always 0/1, so only its LSB is carried per stage.
    typedef struct packed {
        logic taken;
        logic is_branch;
        logic mispredict;
        logic illegal;
        logic result;
    } br_entry_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: branch taken, set-less-than result and
// illegal-encoding detection for one request.
module branch_cond_eval
    import riscv_package::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    aluop,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] operand_a,
    input  logic [DW-1:0] operand_b,
    output logic          taken,
    output logic          result,
    output logic          illegal
);

    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] b_s;
    logic                 eq;
    logic                 lt_s;
    logic                 lt_u;
    branch_cond_e         cond;

    assign a_s  = operand_a;
    assign b_s  = operand_b;
    assign eq   = (operand_a == operand_b);
    assign lt_s = (a_s < b_s);
    assign lt_u = (operand_a < operand_b);

    always_comb begin
        taken   = 1'b0;
        result  = 1'b0;
        illegal = 1'b0;
        cond    = branch_cond_e'(funct3);
        if (aluop == ALUOP_BRANCH) begin
            case (cond)
                BR_BEQ:  taken = eq;
                BR_BNE:  taken = !eq;
                BR_BLT:  taken = lt_s;
                BR_BGE:  taken = !lt_s;
                BR_BLTU: taken = lt_u;
                BR_BGEU: taken = !lt_u;
                default: illegal = 1'b1;
            endcase
        end else if (aluop == ALUOP_SLT) begin
            if (funct3 == F3_SLT) begin
                result = lt_s;
            end else if (funct3 == F3_SLTU) begin
                result = lt_u;
            end
        end
    end

endmodule

// File: rtl/branch_compare_unit.sv
// Branch/SLT compare unit: evaluates the condition and redirect target up
// front, then carries the result through an elastic STAGES-deep pipeline.
module branch_compare_unit
    import riscv_package::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [1:0]    aluop,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] operand_a,
    input  logic [DW-1:0] operand_b,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] imm,
    input  logic          pred_taken,
    input  logic          flush,
    input  logic          cnt_clr,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          taken,
    output logic          is_branch,
    output logic          mispredict,
    output logic          illegal,
    output logic [DW-1:0] result,
    output logic [DW-1:0] redirect_pc,
    output logic [CW-1:0] br_count,
    output logic [CW-1:0] mp_count
);

    localparam logic [DW-1:0] PC_STEP = DW'(4);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    logic            eval_taken;
    logic            eval_result;
    logic            eval_illegal;
    br_entry_t       in_ent;
    logic [DW-1:0]   in_rpc;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] acc;
    logic              nxt_acc;
    br_entry_t         ent_q [STAGES];
    br_entry_t         ent_d [STAGES];
    logic [DW-1:0]     rpc_q [STAGES];
    logic [DW-1:0]     rpc_d [STAGES];
    logic [CW-1:0]     br_cnt_q, br_cnt_d;
    logic [CW-1:0]     mp_cnt_q, mp_cnt_d;
    logic              out_xfer;

    branch_cond_eval #(.DW(DW)) u_eval (
        .aluop     (aluop),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .taken     (eval_taken),
        .result    (eval_result),
        .illegal   (eval_illegal)
    );

    always_comb begin
        in_ent.taken      = eval_taken;
        in_ent.is_branch  = (aluop == ALUOP_BRANCH) && !eval_illegal;
        in_ent.mispredict = in_ent.is_branch && (eval_taken != pred_taken);
        in_ent.illegal    = eval_illegal;
        in_ent.result     = eval_result;
        in_rpc            = pc + (eval_taken ? imm : PC_STEP);
    end

    // A stage accepts when it is empty or its content moves on this edge.
    always_comb begin
        acc     = '0;
        nxt_acc = ready_i;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc[i]  = !vld_q[i] || nxt_acc;
            nxt_acc = acc[i];
        end
    end

    assign ready_o  = acc[0];
    assign out_xfer = vld_q[STAGES-1] && ready_i && !flush;

    always_comb begin
        vld_d = vld_q;
        ent_d = ent_q;
        rpc_d = rpc_q;
        if (acc[0]) begin
            vld_d[0] = valid_i;
            ent_d[0] = in_ent;
            rpc_d[0] = in_rpc;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (acc[i]) begin
                vld_d[i] = vld_q[i-1];
                ent_d[i] = ent_q[i-1];
                rpc_d[i] = rpc_q[i-1];
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (cnt_clr) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else if (out_xfer) begin
            if (ent_q[STAGES-1].is_branch)  br_cnt_d = sat_inc(br_cnt_q);
            if (ent_q[STAGES-1].mispredict) mp_cnt_d = sat_inc(mp_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ent_q[i] <= '0;
                rpc_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                ent_q[i] <= ent_d[i];
                rpc_q[i] <= rpc_d[i];
            end
        end
    end

    assign valid_o     = vld_q[STAGES-1];
    assign taken       = ent_q[STAGES-1].taken;
    assign is_branch   = ent_q[STAGES-1].is_branch;
    assign mispredict  = ent_q[STAGES-1].mispredict;
    assign illegal     = ent_q[STAGES-1].illegal;
    assign result      = {{(DW-1){1'b0}}, ent_q[STAGES-1].result};
    assign redirect_pc = rpc_q[STAGES-1];
    assign br_count    = br_cnt_q;
    assign mp_count    = mp_cnt_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Scoreboard bench for branch_compare_unit: directed scenarios plus random
// traffic, checked against a behavioural model of the compare rules.
module tb_branch_compare_unit;

    localparam int DW     = 32;
    localparam int STAGES = 3;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i, ready_o, valid_o, ready_i;
    logic [1:0]    aluop;
    logic [2:0]    funct3;
    logic [DW-1:0] operand_a, operand_b, pc, imm;
    logic          pred_taken, flush, cnt_clr;
    logic          taken, is_branch, mispredict, illegal;
    logic [DW-1:0] result, redirect_pc;
    logic [CW-1:0] br_count, mp_count;

    always #5 clk = ~clk;

    branch_compare_unit #(.DW(DW), .STAGES(STAGES), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .aluop       (aluop),
        .funct3      (funct3),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .pc          (pc),
        .imm         (imm),
        .pred_taken  (pred_taken),
        .flush       (flush),
        .cnt_clr     (cnt_clr),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .taken       (taken),
        .is_branch   (is_branch),
        .mispredict  (mispredict),
        .illegal     (illegal),
        .result      (result),
        .redirect_pc (redirect_pc),
        .br_count    (br_count),
        .mp_count    (mp_count)
    );

    typedef struct packed {
        logic          taken;
        logic          isb;
        logic          mp;
        logic          ill;
        logic [DW-1:0] res;
        logic [DW-1:0] rpc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   br_m = 0;
    int   mp_m = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] p, input logic [DW-1:0] im,
                                   input logic pred);
        exp_t e;
        logic lt_s, lt_u;
        e    = '0;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        if (op == 2'b01) begin
            case (f3)
                3'd0:    e.taken = (a == b);
                3'd1:    e.taken = (a != b);
                3'd4:    e.taken = lt_s;
                3'd5:    e.taken = !lt_s;
                3'd6:    e.taken = lt_u;
                3'd7:    e.taken = !lt_u;
                default: e.ill = 1'b1;
            endcase
            e.isb = !e.ill;
            e.mp  = e.isb && (e.taken != pred);
        end else if (op == 2'b10) begin
            if (f3 == 3'd2)      e.res = DW'(lt_s);
            else if (f3 == 3'd3) e.res = DW'(lt_u);
        end
        e.rpc = p + (e.taken ? im : 32'd4);
        return e;
    endfunction

    // Monitor: compare presented results, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o) begin
                if (q.size() == 0)
                    check("spurious_valid", 68'(valid_o), 68'(0));
                else
                    check("result", {taken, is_branch, mispredict, illegal, result, redirect_pc}, q[0]);
            end
            check("ready_o", 68'(ready_o), 68'((q.size() < STAGES) || ready_i));
            check("br_count", 68'(br_count), 68'(br_m));
            check("mp_count", 68'(mp_count), 68'(mp_m));
            if (cnt_clr) begin
                br_m = 0;
                mp_m = 0;
            end else if (!flush && valid_o && ready_i && q.size() > 0) begin
                if (q[0].isb && br_m < CMAX) br_m++;
                if (q[0].mp && mp_m < CMAX)  mp_m++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (valid_o && ready_i && q.size() > 0) void'(q.pop_front());
                if (valid_i && ready_o)
                    q.push_back(model(aluop, funct3, operand_a, operand_b, imm == imm ? pc : pc, imm, pred_taken));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] p, input logic [DW-1:0] im, input logic pred);
        valid_i = v; aluop = op; funct3 = f3; operand_a = a; operand_b = b;
        pc = p; imm = im; pred_taken = pred;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (STAGES + 3) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid_o"}, 68'(valid_o), 68'(0));
        check({tag, "_flags"}, 68'({taken, is_branch, mispredict, illegal}), 68'(0));
        check({tag, "_result"}, 68'(result), 68'(0));
        check({tag, "_redirect_pc"}, 68'(redirect_pc), 68'(0));
        check({tag, "_br_count"}, 68'(br_count), 68'(0));
        check({tag, "_mp_count"}, 68'(mp_count), 68'(0));
        check({tag, "_ready_o"}, 68'(ready_o), 68'(1));
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        logic acc_now;
        logic [DW-1:0] a_r;
        int br_save, mp_save;

        set_in(1'b0, 2'b00, 3'b000, '0, '0, '0, '0, 1'b0);
        ready_i = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        #2;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // BLT -1 < 1 taken, predicted not-taken; also measures latency
        set_in(1'b1, 2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        step();
        valid_i = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            @(negedge clk);
            check("latency_early", 68'(valid_o), 68'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("latency", 68'(valid_o), 68'(1));
        @(posedge clk); #1;
        drain();
        check("blt_mp_count", 68'(mp_count), 68'(1));
        check("blt_br_count", 68'(br_count), 68'(1));

        set_in(1'b1, 2'b01, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        step();
        drain();
        check("bltu_br_count", 68'(br_count), 68'(2));
        check("bltu_mp_count", 68'(mp_count), 68'(1));

        set_in(1'b1, 2'b01, 3'b000, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, 1'b1);
        step();
        set_in(1'b1, 2'b10, 3'b011, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        step();
        drain();

        // Five back-to-back BEQs with the consumer stalled for cycles 2..6
        sent = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            ready_i = !(cyc >= 2 && cyc <= 6);
            set_in(sent < 5, 2'b01, 3'b000, 32'(sent), 32'(sent % 2), 32'h1000 + 32'(sent * 4), 32'h40, 1'b0);
            @(negedge clk);
            acc_now = valid_i && ready_o;
            @(posedge clk); #1;
            if (acc_now) sent++;
        end
        check("stall_sent", 68'(sent), 68'(5));
        drain();

        for (int n = 0; n < 1500; n++) begin
            a_r = rnd_op();
            set_in($urandom_range(0, 9) < 7, 2'($urandom), 3'($urandom), a_r,
                   ($urandom_range(0, 3) == 0) ? a_r : rnd_op(), $urandom, $urandom, 1'($urandom));
            ready_i = $urandom_range(0, 9) < 7;
            flush   = $urandom_range(0, 49) == 0;
            cnt_clr = $urandom_range(0, 59) == 0;
            step();
        end
        flush = 1'b0; cnt_clr = 1'b0;
        drain();

        // Mispredict counter saturation, then clear against a same-cycle retire
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int n = 0; n < 17; n++) begin
            set_in(1'b1, 2'b01, 3'b000, 32'(n), 32'(n), 32'(n * 8), 32'h10, 1'b0);
            step();
        end
        drain();
        check("sat_mp_count", 68'(mp_count), 68'(15));
        check("sat_br_count", 68'(br_count), 68'(15));
        set_in(1'b1, 2'b01, 3'b001, 32'h1, 32'h2, 32'h200, 32'h8, 1'b0);
        step();
        valid_i = 1'b0;
        repeat (STAGES - 1) step();
        check("clr_setup_valid_o", 68'(valid_o), 68'(1));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_br_count", 68'(br_count), 68'(0));
        check("clr_mp_count", 68'(mp_count), 68'(0));
        @(posedge clk); #1;
        drain();

        // Flush with a full pipeline and a same-cycle input
        ready_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_in(1'b1, 2'b01, 3'b001, 32'h3, 32'h4, 32'h300 + 32'(n * 4), 32'h8, 1'b0);
            step();
        end
        br_save = br_m;
        mp_save = mp_m;
        set_in(1'b1, 2'b01, 3'b000, 32'h9, 32'h9, 32'h400, 32'h8, 1'b0);
        ready_i = 1'b1;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check("flush_valid_o", 68'(valid_o), 68'(0));
        check("flush_br_count", 68'(br_count), 68'(br_save));
        check("flush_mp_count", 68'(mp_count), 68'(mp_save));
        @(posedge clk); #1;
        drain();

        // Asynchronous reset with entries in flight and non-zero counters
        for (int n = 0; n < 2; n++) begin
            set_in(1'b1, 2'b01, 3'b100, 32'h1, 32'h2, 32'h500, 32'h8, 1'b0);
            step();
        end
        drain();
        ready_i = 1'b0;
        for (int n = 0; n < 2; n++) begin
            set_in(1'b1, 2'b01, 3'b101, 32'h7, 32'h2, 32'h600, 32'h8, 1'b0);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        q.delete();
        br_m = 0;
        mp_m = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(1'b1, 2'b10, 3'b010, 32'h8000_0000, 32'h0, 32'h700, 32'h0, 1'b0);
        step();
        drain();

        check("scoreboard_empty", 68'(q.size()), 68'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_compare_unit.md
BRANCH_COMPARE_UNIT -- requirements
Module: branch_compare_unit

Interface
REQ-001 Parameter DW, 32, operand/PC width in bits (>=8).
REQ-002 Parameter STAGES, 1, pipeline depth in cycles (1..4).
REQ-003 Parameter CW, 16, width of each performance counter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 valid_i  in  1  request valid; ready_o  out  1  unit can accept this cycle.
REQ-007 aluop  in  2  op class (01 branch, 10 set-less-than, other none).
REQ-008 funct3  in  3  condition/op select.
REQ-009 operand_a, operand_b  in  DW  compare operands.
REQ-010 pc, imm  in  DW  branch PC and sign-extended offset.
REQ-011 pred_taken  in  1  front-end prediction.
REQ-012 flush  in  1  kill all in-flight entries; cnt_clr  in  1  zero counters.
REQ-013 valid_o  out  1  result valid; ready_i  in  1  consumer accepts.
REQ-014 taken, is_branch, mispredict, illegal  out  1 each  per-result flags.
REQ-015 result  out  DW  SLT/SLTU result, zero-extended 0/1.
REQ-016 redirect_pc  out  DW  correct next PC for branches.
REQ-017 br_count, mp_count  out  CW  retired-branch and mispredict counters.

Function
REQ-018 Input transfer when valid_i && ready_o; output transfer when valid_o && ready_i.
REQ-019 aluop=01: funct3 000 BEQ (a==b), 001 BNE (a!=b), 100 BLT signed <, 101 BGE signed >=, 110 BLTU unsigned <, 111 BGEU unsigned >=; taken = condition, is_branch=1.
REQ-020 aluop=01 with funct3 010/011: illegal=1, is_branch=0, taken=0, mispredict=0.
REQ-021 aluop=10: funct3 010 result=signed a<b, 011 result=unsigned a<b, other funct3 result=0; is_branch=0, taken=0.
REQ-022 Other aluop: all flags 0, result 0, entry still flows through the pipeline.
REQ-023 Comparisons and target computed combinationally before stage-1 register; stages 2..STAGES delay only.
REQ-024 redirect_pc = taken ? pc+imm : pc+4, modulo 2^DW (wrap-around, no overflow flag).
REQ-025 mispredict = is_branch && (taken != pred_taken).
REQ-026 Latency STAGES cycles from input transfer to valid_o with ready_i held 1; throughput one per cycle.
REQ-027 Each stage holds a valid bit; stage advances when its successor is empty or advancing; ready_o = stage-1 empty or advancing.
REQ-028 ready_i=0 with full pipeline: all stages hold, outputs stable, ready_o=0; no entry lost or duplicated.
REQ-029 flush: all valid bits cleared next edge; a same-cycle input is dropped; a same-cycle output transfer is not counted; valid_o=0 following cycle.
REQ-030 br_count += 1 on output transfer with is_branch; mp_count += 1 on output transfer with mispredict; both saturate at 2^CW-1.
REQ-031 cnt_clr zeros both counters next edge and overrides a same-cycle increment.
REQ-032 Outputs other than valid_o and ready_o are don't-care checked only when valid_o=1.

Reset
REQ-033 rst asserted: all valid bits 0, valid_o 0, counters 0, flags 0, result and redirect_pc 0, immediately and asynchronously.
REQ-034 ready_o = 1 during and after reset; rst mid-operation discards all in-flight entries, none reappear.
REQ-035 Reset deassertion synchronous to clk by the instantiating level; unit accepts on first edge after deassertion.

Structure
REQ-036 riscv_package holds branch_cond_e (BEQ,BNE,BLT,BGE,BLTU,BGEU encodings = funct3), aluop constants, and the pipeline-entry struct type.
REQ-037 One combinational sub-module branch_cond_eval (DW-param) computes taken/result/illegal; the top holds pipeline, handshake and counters.

Verification
REQ-038 STAGES=1, BLT a=0xFFFFFFFF b=1 pred_taken=0, pc=0x100 imm=0x20 -> taken=1, mispredict=1, redirect_pc=0x120, mp_count=1.
REQ-039 BLTU same operands, pred_taken=0 -> taken=0, mispredict=0, redirect_pc=0x104, br_count increments.
REQ-040 STAGES=3, 5 back-to-back BEQ, ready_i=0 for cycles 2-6 -> 5 results in order, each exactly once, ready_o=0 while full.
REQ-041 pc=0xFFFFFFFC imm=8 BEQ a=b -> redirect_pc=0x4; aluop=10 funct3=011 a=1 b=0xFFFFFFFF -> result=1.
REQ-042 flush with 3 in flight and valid_i=1 -> valid_o=0 next cycle, counters unchanged; rst mid-stream -> all outputs 0 asynchronously.
REQ-043 CW=4, 17 mispredicted branches -> mp_count saturates at 15; cnt_clr with a same-cycle transfer -> 0.
